// File: rtl/dogbattle_line_scheduler.sv
// Per-scanline sprite scheduler: walks the dog table high-to-low index and commits up to SLOTS
// visible dogs atomically. Optional feature macro: DOGSCHED_OVF_COUNT_EN (adds ovf_count).
module dogbattle_line_scheduler #(
   parameter int N     = 8,
   parameter int SLOTS = 4,
   parameter int BOX_H = 32
) (
   input  logic                  clk50,
   input  logic                  rst_n,
   input  logic                  line_start,
   input  logic [8:0]            next_y,
   output logic                  rd_req,
   output logic [3:0]            rd_idx,
   input  logic                  rd_ack,
   input  logic [9:0]            rd_x,
   input  logic [8:0]            rd_y,
   input  logic [2:0]            rd_col,
   output logic [SLOTS-1:0]      slot_valid,
   output logic [10*SLOTS-1:0]   slot_x,
   output logic [3*SLOTS-1:0]    slot_col,
   output logic [4*SLOTS-1:0]    slot_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
`ifdef DOGSCHED_OVF_COUNT_EN
   output logic [7:0]            ovf_count,
`endif
   output logic                  restart_err
);

   localparam int CNT_W = $clog2(SLOTS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]            state;
   logic [8:0]            y_q;
   logic [3:0]            idx;
   logic [CNT_W-1:0]      cnt;
   logic                  ovf_stage;
   logic [SLOTS-1:0]      stg_valid;
   logic [10*SLOTS-1:0]   stg_x;
   logic [3*SLOTS-1:0]    stg_col;
   logic [4*SLOTS-1:0]    stg_idx;
   logic                  visible;
   logic                  take;
   logic                  room;

   // Compare at 10 bits so rd_y+BOX_H near the bottom of the screen cannot wrap.
   assign visible = ({1'b0, rd_y} <= {1'b0, y_q}) &&
                    ({1'b0, y_q} < ({1'b0, rd_y} + 10'(BOX_H)));
   assign take    = (state == S_SCAN) && rd_ack && !line_start;
   assign room    = (cnt < CNT_W'(SLOTS));

   assign rd_req  = (state == S_SCAN);
   assign rd_idx  = idx;
   assign busy    = (state == S_SCAN);
   assign done    = (state == S_COMMIT);

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         y_q         <= '0;
         idx         <= '0;
         cnt         <= '0;
         ovf_stage   <= 1'b0;
         stg_valid   <= '0;
         restart_err <= 1'b0;
         slot_valid  <= '0;
         slot_x      <= '0;
         slot_col    <= '0;
         slot_idx    <= '0;
         overflow    <= 1'b0;
`ifdef DOGSCHED_OVF_COUNT_EN
         ovf_count   <= '0;
`endif
      end else begin
         restart_err <= 1'b0;
         // Commit reads the staging bank before any same-edge restart clears it.
         if (state == S_COMMIT) begin
            slot_valid <= stg_valid;
            slot_x     <= stg_x;
            slot_col   <= stg_col;
            slot_idx   <= stg_idx;
            overflow   <= ovf_stage;
`ifdef DOGSCHED_OVF_COUNT_EN
            if (ovf_stage && (ovf_count != 8'hFF))
               ovf_count <= ovf_count + 8'd1;
`endif
         end
         if (line_start) begin
            y_q       <= next_y;
            stg_valid <= '0;
            cnt       <= '0;
            idx       <= 4'(N - 1);
            ovf_stage <= 1'b0;
            state     <= S_SCAN;
            if (state == S_SCAN)
               restart_err <= 1'b1;
         end else begin
            case (state)
               S_SCAN: begin
                  if (rd_ack) begin
                     if (visible) begin
                        if (room) begin
                           for (int k = 0; k < SLOTS; k++)
                              if (cnt == CNT_W'(k))
                                 stg_valid[k] <= 1'b1;
                           cnt <= cnt + 1'b1;
                        end else begin
                           ovf_stage <= 1'b1;
                        end
                     end
                     if (idx == 4'd0)
                        state <= S_COMMIT;
                     else
                        idx <= idx - 4'd1;
                  end
               end
               S_COMMIT: state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   // Staging payload carries no reset; it is cleared at every scan start so unused slots read 0.
   always_ff @(posedge clk50) begin
      if (line_start) begin
         stg_x   <= '0;
         stg_col <= '0;
         stg_idx <= '0;
      end else if (take && visible && room) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (cnt == CNT_W'(k)) begin
               stg_x[10*k +: 10] <= rd_x;
               stg_col[3*k +: 3] <= rd_col;
               stg_idx[4*k +: 4] <= idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_dogbattle_line_scheduler.sv
// Directed bench for dogbattle_line_scheduler: a dog table model answers the read port.
module tb_dogbattle_line_scheduler;

   logic        clk50 = 1'b0;
   logic        rst_n;
   logic        line_start;
   logic [8:0]  next_y;
   logic        rd_req;
   logic [3:0]  rd_idx;
   logic        rd_ack;
   logic [9:0]  rd_x;
   logic [8:0]  rd_y;
   logic [2:0]  rd_col;
   logic [3:0]  slot_valid;
   logic [39:0] slot_x;
   logic [11:0] slot_col;
   logic [15:0] slot_idx;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        restart_err;
`ifdef DOGSCHED_OVF_COUNT_EN
   logic [7:0]  ovf_count;
`endif

   logic [9:0]  dog_x   [16];
   logic [8:0]  dog_y   [16];
   logic [2:0]  dog_col [16];

   int checks = 0;
   int errors = 0;
   logic req_at1, busy_at1;

   always #10 clk50 = ~clk50;

   assign rd_x   = dog_x[rd_idx];
   assign rd_y   = dog_y[rd_idx];
   assign rd_col = dog_col[rd_idx];

   dogbattle_line_scheduler #(.N(8), .SLOTS(4), .BOX_H(32)) dut (
      .clk50(clk50), .rst_n(rst_n), .line_start(line_start), .next_y(next_y),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_x(rd_x), .rd_y(rd_y),
      .rd_col(rd_col), .slot_valid(slot_valid), .slot_x(slot_x), .slot_col(slot_col),
      .slot_idx(slot_idx), .busy(busy), .done(done), .overflow(overflow),
`ifdef DOGSCHED_OVF_COUNT_EN
      .ovf_count(ovf_count),
`endif
      .restart_err(restart_err)
   );

   task automatic set_all_y(input logic [8:0] y);
      for (int i = 0; i < 16; i++) dog_y[i] = y;
   endtask

   // Starts a line at cycle 0; optionally stalls st_n cycles on index st_idx.
   // Returns the cycle done was seen and how many cycles rd_idx sat on st_idx.
   task automatic run_line(input logic [8:0] y, input int st_idx, input int st_n,
                           output int dcyc, output int watch);
      int n;
      int cyc;
      n = st_n;
      watch = 0;
      dcyc = -1;
      @(negedge clk50);
      line_start = 1'b1;
      next_y = y;
      rd_ack = 1'b1;
      @(negedge clk50);
      line_start = 1'b0;
      cyc = 1;
      req_at1 = rd_req;
      busy_at1 = busy;
      while (cyc < 60) begin
         if (done) begin
            dcyc = cyc;
            break;
         end
         if (rd_req && (int'(rd_idx) == st_idx)) watch++;
         if (n > 0 && rd_req && (int'(rd_idx) == st_idx)) begin
            rd_ack = 1'b0;
            n--;
         end else begin
            rd_ack = 1'b1;
         end
         @(negedge clk50);
         cyc++;
      end
      rd_ack = 1'b1;
      @(negedge clk50);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      line_start = 1'b0;
      next_y = '0;
      rd_ack = 1'b1;
      repeat (2) @(negedge clk50);
      checks++; if ({rd_req, busy, done, overflow, restart_err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {rd_req, busy, done, overflow, restart_err}); end
      checks++; if (rd_idx !== 4'd0) begin
         errors++; $display("FAIL reset_rd_idx got %0d want 0", rd_idx); end
      checks++; if ({slot_valid, slot_x, slot_col, slot_idx} !== 72'd0) begin
         errors++; $display("FAIL reset_slots got %h want 0", {slot_valid, slot_x, slot_col, slot_idx}); end
`ifdef DOGSCHED_OVF_COUNT_EN
      checks++; if (ovf_count !== 8'd0) begin
         errors++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
`endif
      rst_n = 1'b1;
      @(negedge clk50);
   endtask

   task automatic test_none_visible;
      int dc, w;
      set_all_y(9'd300);
      run_line(9'd100, -1, 0, dc, w);
      checks++; if (req_at1 !== 1'b1 || busy_at1 !== 1'b1) begin
         errors++; $display("FAIL none_req_cycle1 got req=%b busy=%b want 1 1", req_at1, busy_at1); end
      checks++; if (dc !== 9) begin
         errors++; $display("FAIL none_done_cycle got %0d want 9", dc); end
      checks++; if (slot_valid !== 4'b0000 || overflow !== 1'b0) begin
         errors++; $display("FAIL none_result got valid=%b ovf=%b want 0000 0", slot_valid, overflow); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL none_done_pulse got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_three_visible(input int st_idx, input int st_n, input int want_dc, input int want_w);
      int dc, w;
      set_all_y(9'd300);
      dog_y[1] = 9'd90; dog_y[3] = 9'd90; dog_y[6] = 9'd90;
      run_line(9'd100, st_idx, st_n, dc, w);
      checks++; if (dc !== want_dc) begin
         errors++; $display("FAIL three_done_cycle got %0d want %0d", dc, want_dc); end
      if (st_n > 0) begin
         checks++; if (w !== want_w) begin
            errors++; $display("FAIL stall_idx_hold got %0d want %0d", w, want_w); end
      end
      checks++; if (slot_valid !== 4'b0111) begin
         errors++; $display("FAIL three_valid got %b want 0111", slot_valid); end
      checks++; if (slot_idx !== 16'h0136) begin
         errors++; $display("FAIL three_idx got %h want 0136", slot_idx); end
      checks++; if (slot_x !== {10'd0, 10'd45, 10'd125, 10'd245}) begin
         errors++; $display("FAIL three_x got %h want %h", slot_x, {10'd0, 10'd45, 10'd125, 10'd245}); end
      checks++; if (slot_col !== {3'd0, 3'd2, 3'd0, 3'd5}) begin
         errors++; $display("FAIL three_col got %h want %h", slot_col, {3'd0, 3'd2, 3'd0, 3'd5}); end
      checks++; if (overflow !== 1'b0) begin
         errors++; $display("FAIL three_ovf got %b want 0", overflow); end
   endtask

   task automatic test_boundary;
      int dc, w;
      set_all_y(9'd300);
      dog_y[0] = 9'd100;
      run_line(9'd100, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0001 || slot_idx !== 16'h0000) begin
         errors++; $display("FAIL bound_top got valid=%b idx=%h want 0001 0000", slot_valid, slot_idx); end
      run_line(9'd132, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0000) begin
         errors++; $display("FAIL bound_bottom got %b want 0000", slot_valid); end
      run_line(9'd131, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0001) begin
         errors++; $display("FAIL bound_last_line got %b want 0001", slot_valid); end
      dog_y[0] = 9'd460;
      run_line(9'd479, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0001) begin
         errors++; $display("FAIL bound_nowrap got %b want 0001", slot_valid); end
      run_line(9'd459, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0000) begin
         errors++; $display("FAIL bound_above got %b want 0000", slot_valid); end
   endtask

   task automatic test_overflow;
      int dc, w;
      set_all_y(9'd90);
      run_line(9'd100, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b1111 || slot_idx !== 16'h4567) begin
         errors++; $display("FAIL ovf_slots got valid=%b idx=%h want 1111 4567", slot_valid, slot_idx); end
      checks++; if (slot_x !== {10'd165, 10'd205, 10'd245, 10'd285}) begin
         errors++; $display("FAIL ovf_x got %h want %h", slot_x, {10'd165, 10'd205, 10'd245, 10'd285}); end
      checks++; if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
      set_all_y(9'd300);
      dog_y[0] = 9'd90; dog_y[2] = 9'd90;
      run_line(9'd100, -1, 0, dc, w);
      checks++; if (slot_valid !== 4'b0011 || slot_idx !== 16'h0002) begin
         errors++; $display("FAIL ovf_next_slots got valid=%b idx=%h want 0011 0002", slot_valid, slot_idx); end
      checks++; if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
`ifdef DOGSCHED_OVF_COUNT_EN
      checks++; if (ovf_count !== 8'd1) begin
         errors++; $display("FAIL ovf_count got %0d want 1", ovf_count); end
`endif
   endtask

   task automatic test_restart;
      int cyc;
      int dc;
      dog_y[2] = 9'd190;
      dog_y[5] = 9'd180;
      @(negedge clk50);
      line_start = 1'b1; next_y = 9'd100;
      @(negedge clk50);
      line_start = 1'b0;
      repeat (3) @(negedge clk50);
      checks++; if (restart_err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL restart_pre got err=%b busy=%b want 0 1", restart_err, busy); end
      line_start = 1'b1; next_y = 9'd200;
      @(negedge clk50);
      line_start = 1'b0;
      checks++; if (restart_err !== 1'b1) begin
         errors++; $display("FAIL restart_pulse got %b want 1", restart_err); end
      checks++; if (slot_valid !== 4'b0111 || slot_idx !== 16'h0136) begin
         errors++; $display("FAIL restart_retain got valid=%b idx=%h want 0111 0136", slot_valid, slot_idx); end
      cyc = 5;
      dc = -1;
      while (cyc < 60) begin
         if (done) begin dc = cyc; break; end
         @(negedge clk50);
         cyc++;
         if (cyc == 6) begin
            checks++; if (restart_err !== 1'b0) begin
               errors++; $display("FAIL restart_one_cycle got %b want 0", restart_err); end
         end
      end
      checks++; if (dc !== 13) begin
         errors++; $display("FAIL restart_done_cycle got %0d want 13", dc); end
      @(negedge clk50);
      checks++; if (slot_valid !== 4'b0011 || slot_idx !== 16'h0025) begin
         errors++; $display("FAIL restart_result got valid=%b idx=%h want 0011 0025", slot_valid, slot_idx); end
      checks++; if (slot_x !== {10'd0, 10'd0, 10'd85, 10'd205} || slot_col !== {3'd0, 3'd0, 3'd1, 3'd6}) begin
         errors++; $display("FAIL restart_payload got x=%h col=%h", slot_x, slot_col); end
   endtask

   task automatic test_reset_mid_scan;
      int seen;
      seen = 0;
      @(negedge clk50);
      line_start = 1'b1; next_y = 9'd100;
      @(negedge clk50);
      line_start = 1'b0;
      repeat (2) @(negedge clk50);
      rst_n = 1'b0;
      #1;
      checks++; if ({rd_req, busy, done, overflow, restart_err} !== 5'b0 || rd_idx !== 4'd0) begin
         errors++; $display("FAIL midrst_ctrl got %b idx=%0d want 00000 0", {rd_req, busy, done, overflow, restart_err}, rd_idx); end
      checks++; if ({slot_valid, slot_x, slot_col, slot_idx} !== 72'd0) begin
         errors++; $display("FAIL midrst_slots got %h want 0", {slot_valid, slot_x, slot_col, slot_idx}); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk50);
         if (i == 3) rst_n = 1'b1;
         if (done) seen++;
      end
      checks++; if (seen !== 0) begin
         errors++; $display("FAIL midrst_no_done got %0d want 0", seen); end
`ifdef DOGSCHED_OVF_COUNT_EN
      checks++; if (ovf_count !== 8'd0) begin
         errors++; $display("FAIL midrst_ovf_count got %0d want 0", ovf_count); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         dog_x[i]   = 10'(40 * i + 5);
         dog_col[i] = 3'(i) ^ 3'd3;
         dog_y[i]   = 9'd300;
      end
      test_reset();
      test_none_visible();
      test_three_visible(-1, 0, 9, 0);
      test_boundary();
      test_overflow();
      test_three_visible(5, 3, 12, 4);
      test_restart();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dogbattle_line_scheduler.md
# dogbattle_line_scheduler

Per-scanline sprite scheduler for the 8-dog battle display. At each line start it walks the dog record table over a request/acknowledge read port and selects up to SLOTS dogs whose boxes intersect the next scanline. It commits them atomically into a double-buffered slot bank that the pixel generator reads during the following active line. It sits between the game core's dog register file and the VGA pixel path, in the clk50 domain.

## Interface
- N, 8, number of dog records (2..16)
- SLOTS, 4, sprite slots per line (1..N)
- BOX_H, 32, dog box height in lines
- clk50  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- line_start  in  1  one-cycle pulse at start of horizontal blanking
- next_y  in  9  scanline to be scheduled (0..479), sampled on line_start
- rd_req  out  1  record read request
- rd_idx  out  4  record index requested
- rd_ack  in  1  record data valid this cycle (qualifies rd_x/rd_y/rd_col)
- rd_x  in  10  record box left edge
- rd_y  in  9  record box top edge
- rd_col  in  3  record colour index
- slot_valid  out  SLOTS  committed slot occupied
- slot_x  out  10*SLOTS  committed x, slot k at [10k+9:10k]
- slot_col  out  3*SLOTS  committed colour
- slot_idx  out  4*SLOTS  committed dog index
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse on commit
- overflow  out  1  last committed line had more visible dogs than SLOTS
- restart_err  out  1  one-cycle pulse when line_start aborts a scan

## Operation
- States: IDLE, SCAN, COMMIT.
- IDLE: rd_req=0, busy=0. On line_start: latch next_y into y_q; clear staging valid bits and staging count; idx=N-1; set ovf_stage=0; go SCAN.
- SCAN: rd_req=1, rd_idx=idx, busy=1. Record is consumed in a cycle with rd_req&&rd_ack.
  - Visible iff rd_y <= y_q and y_q < rd_y+BOX_H. The sum is computed at 10 bits; no wrap.
  - Visible and count<SLOTS: write {rd_x,rd_col,idx} into staging slot[count]; count++.
  - Visible and count==SLOTS: ovf_stage=1.
  - If idx==0, go COMMIT; else idx--.
- Scan order runs from N-1 down to 0, so slot 0 holds the highest-index visible dog. This matches draw priority (higher index on top) and drops lowest-priority dogs first on overflow.
- COMMIT: one cycle. Copy staging into slot_valid/x/col/idx and ovf_stage into overflow; done=1; go IDLE.
- Committed outputs change only in COMMIT. They are stable for the whole following line.
- line_start during SCAN: abort the scan, pulse restart_err, and restart exactly as from IDLE with the new next_y. Committed outputs are untouched.
- line_start during COMMIT: the commit completes, and the same edge starts the new scan (state goes SCAN directly).
- rd_idx holds when rd_ack=0; the wait may be unbounded.

## Timing
- Reset values: rd_req=0, rd_idx=0, slot_valid=0, slot_x=0, slot_col=0, slot_idx=0, busy=0, done=0, overflow=0, restart_err=0, state IDLE.
- Reset mid-scan: immediate return to reset values. No commit.
- line_start at cycle 0 gives rd_req=1 at cycle 1.
- With rd_ack tied high, one record is consumed per cycle: the last record at cycle N, COMMIT/done at cycle N+1.
- Each cycle of rd_ack=0 adds one cycle of latency.
- Worst case with zero-wait ack is N+1 cycles. This is well inside hblank (320 clk50 cycles).

## Configuration
- DOGSCHED_OVF_COUNT_EN defined: adds output ovf_count (8 bits), reset 0.
  - Increments at each COMMIT with ovf_stage=1.
  - Saturates at 255.
  - Cleared only by rst_n.
- Not defined: port absent; overflow flag behaviour unchanged.

## Test plan
- Reset, then line_start with next_y=100, rd_ack=1, all dogs at y=300 -> done at cycle 9, slot_valid=0000, overflow=0.
- Dogs 1,3,6 at y=90 and others at y=300, next_y=100 -> slot_idx = {6,3,1} in slots 0..2, slot_valid=0111, correct x/col per slot.
- Boundary lines: dog at y=100 with next_y=100 -> visible; with next_y=132 -> not visible; dog at y=460 with next_y=479 -> visible, no wrap.
- All 8 dogs visible, SLOTS=4 -> slots hold idx 7,6,5,4, overflow=1. Next line with 2 visible -> overflow=0. With DOGSCHED_OVF_COUNT_EN, ovf_count=1.
- rd_ack stalls 3 cycles on idx 5 -> rd_idx holds at 5, done delayed to cycle 12, results identical to zero-wait run.
- line_start reasserted at cycle 4 with next_y=200 -> restart_err pulse, previous commit retained, new scan commits next_y=200 results. Separately, rst_n low at cycle 3 -> all outputs 0, no done.
